// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the unified-memory bus arbiter:
//   - memory command codes driven on mem_rw
//   - arbiter FSM state encoding
//   - default parameter values and an index-width helper
// No ports (package).
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    localparam logic [1:0] MEM_IDLE = 2'b00;
    localparam logic [1:0] MEM_RD   = 2'b01;
    localparam logic [1:0] MEM_WR   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arbState_t;

    localparam int DEF_N_REQ      = 3;
    localparam int DEF_AW         = 8;
    localparam int DEF_DW         = 8;
    localparam int DEF_MEM_LAT    = 1;
    localparam int DEF_STARVE_MAX = 4;

    // A single requester still needs a one-bit owner index.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// Bundles the requester handshake and the memory-side bus of the arbiter.
//   Requester side : req, we, addr, wdata (packed per requester) -> gnt, ack, rdata
//   Memory side    : mem_addr, mem_rw, mem_wdata -> mem_rdata
//   Status         : busy, owner
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus the memory cell)
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if
    import mem_bus_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) ();

    localparam int IDX_W = idxWidth(N_REQ);

    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    we;
    logic [N_REQ*AW-1:0] addr;
    logic [N_REQ*DW-1:0] wdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    ack;
    logic [DW-1:0]       rdata;
    logic [AW-1:0]       mem_addr;
    logic [1:0]          mem_rw;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_rdata;
    logic                busy;
    logic [IDX_W-1:0]    owner;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, ack, rdata, mem_addr, mem_rw, mem_wdata, busy, owner
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, ack, rdata, mem_addr, mem_rw, mem_wdata, busy, owner
    );

endinterface

// File: rtl/mem_bus_arbiter_prio_sel.sv
// ---------------------------------------------------------------------------
// mem_bus_prio_sel
// Combinational two-level priority selector.
//   req_i       : active requests
//   starved_i   : requests that have waited long enough to be boosted
//   winOneHot_o : one-hot winner (all zero when nothing requests)
//   winIdx_o    : index of the winner
// Starved requesters form the candidate set whenever any exists; within the
// candidate set the lowest index wins.
// ---------------------------------------------------------------------------
module mem_bus_prio_sel
    import mem_bus_arbiter_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int IDX_W = idxWidth(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] starved_i,
    output logic [N_REQ-1:0] winOneHot_o,
    output logic [IDX_W-1:0] winIdx_o
);

    logic [N_REQ-1:0] candidates;

    // Walk from the top index down so the lowest-index candidate is the last
    // one written and therefore wins.
    always_comb begin
        candidates  = (|(starved_i & req_i)) ? (starved_i & req_i) : req_i;
        winOneHot_o = '0;
        winIdx_o    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (candidates[i]) begin
                winOneHot_o    = '0;
                winOneHot_o[i] = 1'b1;
                winIdx_o       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one unified instruction/data memory between N_REQ requesters.
// Each transaction: arbitrate in IDLE, hold the memory command for MEM_LAT
// cycles in ACCESS, pulse ack for one cycle in DONE. A requester that has
// waited STARVE_MAX cycles is boosted ahead of the fixed priority order.
// Ports:
//   eclk  : system clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : mem_bus_arbiter_if.slave (requester handshake + memory bus)
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input logic              eclk,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);

    localparam int IDX_W = idxWidth(N_REQ);
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STARVE_MAX);

    arbState_t        state_q, state_d;
    logic [LAT_W-1:0] latCnt_q, latCnt_d;
    logic [CNT_W-1:0] waitCnt_q [N_REQ];
    logic [CNT_W-1:0] waitCnt_d [N_REQ];
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [AW-1:0]    memAddr_q, memAddr_d;
    logic [1:0]       memRw_q, memRw_d;
    logic [DW-1:0]    memWdata_q, memWdata_d;
    logic             busy_q, busy_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    logic [N_REQ-1:0] starved;
    logic [N_REQ-1:0] winOneHot;
    logic [IDX_W-1:0] winIdx;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            starved[i] = bus.req[i] && (waitCnt_q[i] >= CNT_SAT);
        end
    end

    mem_bus_prio_sel #(.N_REQ(N_REQ)) u_prioSel (
        .req_i       (bus.req),
        .starved_i   (starved),
        .winOneHot_o (winOneHot),
        .winIdx_o    (winIdx)
    );

    // FSM next state and output-register updates. gnt and ack default low so
    // they only ever pulse for the single cycle that sets them.
    always_comb begin
        state_d    = state_q;
        latCnt_d   = latCnt_q;
        gnt_d      = '0;
        ack_d      = '0;
        rdata_d    = rdata_q;
        memAddr_d  = memAddr_q;
        memRw_d    = memRw_q;
        memWdata_d = memWdata_q;
        busy_d     = busy_q;
        owner_d    = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    memAddr_d  = bus.addr[winIdx * AW +: AW];
                    memWdata_d = bus.wdata[winIdx * DW +: DW];
                    memRw_d    = bus.we[winIdx] ? MEM_WR : MEM_RD;
                    gnt_d      = winOneHot;
                    owner_d    = winIdx;
                    latCnt_d   = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (latCnt_q == LAT_LAST) begin
                    if (memRw_q == MEM_RD) begin
                        rdata_d = bus.mem_rdata;
                    end
                    memRw_d         = MEM_IDLE;
                    ack_d[owner_q]  = 1'b1;
                    state_d         = ST_DONE;
                end else begin
                    latCnt_d = latCnt_q + LAT_W'(1);
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Wait counters: a pending requester that is not the current winner ages
    // by one per cycle and saturates. In IDLE the winner is the one being
    // granted now; in ACCESS/DONE it is the registered owner.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            if (!bus.req[i] ||
                ((state_q == ST_IDLE) ? winOneHot[i] : (owner_q == IDX_W'(i)))) begin
                waitCnt_d[i] = '0;
            end else if (waitCnt_q[i] != CNT_SAT) begin
                waitCnt_d[i] = waitCnt_q[i] + CNT_W'(1);
            end else begin
                waitCnt_d[i] = waitCnt_q[i];
            end
        end
    end

    // State and output registers; reset overrides everything, including an
    // access in flight, so no ack is produced for a cut-off transaction.
    always_ff @(posedge eclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            latCnt_q   <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            memAddr_q  <= '0;
            memRw_q    <= MEM_IDLE;
            memWdata_q <= '0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                waitCnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            latCnt_q   <= latCnt_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            memAddr_q  <= memAddr_d;
            memRw_q    <= memRw_d;
            memWdata_q <= memWdata_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            for (int i = 0; i < N_REQ; i++) begin
                waitCnt_q[i] <= waitCnt_d[i];
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = memAddr_q;
    assign bus.mem_rw    = memRw_q;
    assign bus.mem_wdata = memWdata_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;

endmodule
